lavanderia_multi: RTL and testbench

Parametrised successor of the laundry front-end controller. It serves N machines running concurrently. The transaction sequence is: select a free machine, accumulate bill credit, choose a wash mode priced per mode, then release. Release starts a per-machine countdown and refunds change.
It sits between the debouncers/tick divider and the 7-segment display mux. All event inputs are already debounced single-cycle pulses.

---
 rtl/lavanderia_pkg.sv | 41 ++++
 rtl/lav_timer.sv | 32 +++
 rtl/lavanderia_multi.sv | 169 ++++++++++++++++
 tb/tb_lavanderia_multi.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lavanderia_pkg.sv
// Shared definitions for the multi-machine laundry controller: state
// encoding, bill decoding and per-mode price/run-time lookup.
package lavanderia_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAY   = 2'd1,
    START = 2'd2
  } lav_state_t;

  function automatic logic [3:0] bill_value(input logic [1:0] code);
    case (code)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

  // Mode 3 is illegal; it maps to 0 and is rejected by the caller.
  function automatic int mode_price(input logic [1:0] m, input int p0, input int p1,
                                    input int p2);
    case (m)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return 0;
    endcase
  endfunction

  function automatic int mode_run(input logic [1:0] m, input int t0, input int t1,
                                  input int t2);
    case (m)
      2'd0:    return t0;
      2'd1:    return t1;
      2'd2:    return t2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/lav_timer.sv
// Single-machine countdown: load wins over tick; done pulses on the 1->0 step.
module lav_timer #(
  parameter int T_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_en,
  input  logic           load,
  input  logic [T_W-1:0] load_val,
  output logic           busy,
  output logic           done,
  output logic [T_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (tick_en && count != '0) begin
        count <= count - 1'b1;
        if (count == T_W'(1)) done <= 1'b1;
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/lavanderia_multi.sv
// Laundry front-end serving N_MAQ concurrent machines: select, pay, choose
// mode, start. Event inputs are single-cycle pulses; there is no backpressure.
module lavanderia_multi
  import lavanderia_pkg::*;
#(
  parameter int N_MAQ    = 4,
  parameter int ID_W     = 3,
  parameter int CREDIT_W = 6,
  parameter int T_W      = 8,
  parameter int PRICE0   = 4,
  parameter int PRICE1   = 7,
  parameter int PRICE2   = 10,
  parameter int RUN_T0   = 5,
  parameter int RUN_T1   = 8,
  parameter int RUN_T2   = 12,
  parameter int TIMEOUT  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_en,
  input  logic                sel_vld,
  input  logic [ID_W-1:0]     maq_id,
  input  logic                cash_vld,
  input  logic [1:0]          bill_code,
  input  logic                mode_vld,
  input  logic [1:0]          mode,
  input  logic                cancel,
  input  logic [ID_W-1:0]     view_id,
  output logic [1:0]          state,
  output logic [ID_W-1:0]     sel_maq,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_MAQ-1:0]    busy,
  output logic [N_MAQ-1:0]    done,
  output logic                refund_vld,
  output logic [CREDIT_W-1:0] refund_amt,
  output logic                err,
  output logic [T_W-1:0]      rem_view
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  lav_state_t          state_q, state_d;
  logic [ID_W-1:0]     sel_d;
  logic [CREDIT_W-1:0] credit_d, refund_amt_d, price_req, price_run, change;
  logic [1:0]          mode_q, mode_d;
  logic [TO_W-1:0]     tout_q, tout_d;
  logic                refund_vld_d, err_d, sel_ok, timed_out;
  logic [CREDIT_W:0]   cash_sum;
  logic [T_W-1:0]      run_len;
  logic [N_MAQ-1:0]    load;
  logic [T_W-1:0]      cnt [N_MAQ];

  // An out-of-range id never matches, so it is rejected like a busy machine.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < N_MAQ; i++)
      if (maq_id == ID_W'(i) && !busy[i]) sel_ok = 1'b1;
  end

  assign price_req = CREDIT_W'(mode_price(mode, PRICE0, PRICE1, PRICE2));
  assign price_run = CREDIT_W'(mode_price(mode_q, PRICE0, PRICE1, PRICE2));
  assign change    = credit - price_run;
  assign run_len   = T_W'(mode_run(mode_q, RUN_T0, RUN_T1, RUN_T2));
  assign cash_sum  = {1'b0, credit} + (CREDIT_W + 1)'(bill_value(bill_code));
  assign timed_out = tick_en && !mode_vld && !cash_vld && (tout_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_maq;
    credit_d     = credit;
    mode_d       = mode_q;
    tout_d       = tout_q;
    refund_vld_d = 1'b0;
    refund_amt_d = '0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          if (sel_ok) begin
            sel_d   = maq_id;
            tout_d  = '0;
            state_d = PAY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAY: begin
        if (cancel || timed_out) begin
          refund_vld_d = (credit != '0);
          refund_amt_d = credit;
          credit_d     = '0;
          tout_d       = '0;
          state_d      = IDLE;
        end else if (mode_vld) begin
          tout_d = '0;
          if (mode == 2'd3 || credit < price_req) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode;
            state_d = START;
          end
        end else if (cash_vld) begin
          tout_d = '0;
          if (cash_sum[CREDIT_W]) err_d = 1'b1;
          else                    credit_d = cash_sum[CREDIT_W-1:0];
        end else if (tick_en) begin
          tout_d = tout_q + 1'b1;
        end
      end
      START: begin
        refund_vld_d = (change != '0);
        refund_amt_d = change;
        credit_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_maq    <= '0;
      credit     <= '0;
      mode_q     <= '0;
      tout_q     <= '0;
      refund_vld <= 1'b0;
      refund_amt <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_maq    <= sel_d;
      credit     <= credit_d;
      mode_q     <= mode_d;
      tout_q     <= tout_d;
      refund_vld <= refund_vld_d;
      refund_amt <= refund_amt_d;
      err        <= err_d;
    end
  end

  assign state = state_q;

  always_comb begin
    for (int i = 0; i < N_MAQ; i++)
      load[i] = (state_q == START) && (sel_maq == ID_W'(i));
  end

  for (genvar g = 0; g < N_MAQ; g++) begin : g_maq
    lav_timer #(.T_W(T_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .load     (load[g]),
      .load_val (run_len),
      .busy     (busy[g]),
      .done     (done[g]),
      .count    (cnt[g])
    );
  end

  always_comb begin
    rem_view = '0;
    for (int i = 0; i < N_MAQ; i++)
      if (view_id == ID_W'(i)) rem_view = cnt[i];
  end

endmodule

// File: tb/tb_lavanderia_multi.sv
// Directed bench for lavanderia_multi: one task per scenario, inline checks.
module tb_lavanderia_multi;
  localparam int N_MAQ = 4, ID_W = 3, CREDIT_W = 6, T_W = 8;

  logic clk = 1'b0, reset = 1'b0, tick_en = 1'b0, sel_vld = 1'b0;
  logic cash_vld = 1'b0, mode_vld = 1'b0, cancel = 1'b0;
  logic [ID_W-1:0] maq_id = '0, view_id = '0;
  logic [1:0] bill_code = '0, mode = '0;
  logic [1:0] state;
  logic [ID_W-1:0] sel_maq;
  logic [CREDIT_W-1:0] credit, refund_amt;
  logic [N_MAQ-1:0] busy, done;
  logic refund_vld, err;
  logic [T_W-1:0] rem_view;
  int n_checks = 0, n_fail = 0;

  lavanderia_multi dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .sel_vld(sel_vld), .maq_id(maq_id),
    .cash_vld(cash_vld), .bill_code(bill_code), .mode_vld(mode_vld), .mode(mode),
    .cancel(cancel), .view_id(view_id), .state(state), .sel_maq(sel_maq), .credit(credit),
    .busy(busy), .done(done), .refund_vld(refund_vld), .refund_amt(refund_amt), .err(err),
    .rem_view(rem_view)
  );

  always #5 clk = ~clk;

  task automatic step(); @(posedge clk); #1; endtask
  task automatic do_reset(); reset = 1'b0; step(); reset = 1'b1; step(); endtask
  task automatic sel(input logic [ID_W-1:0] id); sel_vld = 1'b1; maq_id = id; step(); sel_vld = 1'b0; endtask
  task automatic cash(input logic [1:0] c); cash_vld = 1'b1; bill_code = c; step(); cash_vld = 1'b0; endtask
  task automatic pick(input logic [1:0] m); mode_vld = 1'b1; mode = m; step(); mode_vld = 1'b0; endtask
  task automatic tick(); tick_en = 1'b1; step(); tick_en = 1'b0; endtask

  task automatic test_reset();
    reset = 1'b0; step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL rst_credit: got %0d want 0", credit); end
    n_checks++; if (busy !== 4'd0 || done !== 4'd0) begin n_fail++; $display("FAIL rst_busy_done: got %b/%b want 0000/0000", busy, done); end
    n_checks++; if (refund_vld !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got refund %b err %b want 0 0", refund_vld, err); end
    n_checks++; if (sel_maq !== 3'd0 || rem_view !== 8'd0) begin n_fail++; $display("FAIL rst_sel_rem: got %0d/%0d want 0/0", sel_maq, rem_view); end
    reset = 1'b1; step();
  endtask

  task automatic test_idle_ignore();
    do_reset();
    cash(2'd3);
    n_checks++; if (credit !== 6'd0 || err !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL idle_cash: got credit %0d err %b state %0d want 0 0 0", credit, err, state); end
    pick(2'd0);
    n_checks++; if (err !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL idle_mode: got err %b state %0d want 0 0", err, state); end
    cancel = 1'b1; step(); cancel = 1'b0;
    n_checks++; if (refund_vld !== 1'b0) begin n_fail++; $display("FAIL idle_cancel: got refund %b want 0", refund_vld); end
  endtask

  task automatic test_mode_price();
    do_reset(); view_id = 3'd2;
    sel(3'd2);
    n_checks++; if (state !== 2'd1 || sel_maq !== 3'd2) begin n_fail++; $display("FAIL mp_sel: got state %0d sel %0d want 1 2", state, sel_maq); end
    cash(2'd2); cash(2'd0);
    n_checks++; if (credit !== 6'd6) begin n_fail++; $display("FAIL mp_credit6: got %0d want 6", credit); end
    pick(2'd1);
    n_checks++; if (err !== 1'b1 || credit !== 6'd6 || state !== 2'd1) begin n_fail++; $display("FAIL mp_short: got err %b credit %0d state %0d want 1 6 1", err, credit, state); end
    pick(2'd3);
    n_checks++; if (err !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL mp_mode3: got err %b state %0d want 1 1", err, state); end
    cash(2'd0);
    n_checks++; if (credit !== 6'd7 || err !== 1'b0) begin n_fail++; $display("FAIL mp_credit7: got %0d err %b want 7 0", credit, err); end
    pick(2'd1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mp_start: got state %0d want 2", state); end
    step();
    n_checks++; if (state !== 2'd0 || refund_vld !== 1'b0 || credit !== 6'd0) begin n_fail++; $display("FAIL mp_after: got state %0d refund %b credit %0d want 0 0 0", state, refund_vld, credit); end
    n_checks++; if (busy !== 4'b0100 || rem_view !== 8'd8) begin n_fail++; $display("FAIL mp_load: got busy %b rem %0d want 0100 8", busy, rem_view); end
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (rem_view !== 8'd1 || busy !== 4'b0100 || done !== 4'd0) begin n_fail++; $display("FAIL mp_t7: got rem %0d busy %b done %b want 1 0100 0000", rem_view, busy, done); end
    tick();
    n_checks++; if (done !== 4'b0100 || busy !== 4'b0000) begin n_fail++; $display("FAIL mp_done: got done %b busy %b want 0100 0000", done, busy); end
    step();
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mp_done_pulse: got %b want 0000", done); end
  endtask

  task automatic test_refund_busy();
    do_reset(); view_id = 3'd0;
    sel(3'd0); cash(2'd3); pick(2'd0); step();
    n_checks++; if (refund_vld !== 1'b1 || refund_amt !== 6'd6) begin n_fail++; $display("FAIL rb_refund: got vld %b amt %0d want 1 6", refund_vld, refund_amt); end
    n_checks++; if (busy !== 4'b0001 || rem_view !== 8'd5) begin n_fail++; $display("FAIL rb_timer: got busy %b rem %0d want 0001 5", busy, rem_view); end
    step();
    n_checks++; if (refund_vld !== 1'b0) begin n_fail++; $display("FAIL rb_refund_pulse: got %b want 0", refund_vld); end
    sel(3'd0);
    n_checks++; if (err !== 1'b1 || state !== 2'd0) begin n_fail++; $display("FAIL rb_busy_sel: got err %b state %0d want 1 0", err, state); end
  endtask

  task automatic test_cancel_priority();
    do_reset();
    sel(3'd1); cash(2'd2); cash(2'd1);
    cash_vld = 1'b1; bill_code = 2'd3; cancel = 1'b1; step(); cash_vld = 1'b0; cancel = 1'b0;
    n_checks++; if (refund_vld !== 1'b1 || refund_amt !== 6'd7) begin n_fail++; $display("FAIL cp_refund: got vld %b amt %0d want 1 7", refund_vld, refund_amt); end
    n_checks++; if (credit !== 6'd0 || state !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL cp_state: got credit %0d state %0d err %b want 0 0 0", credit, state, err); end
  endtask

  task automatic test_timeout();
    do_reset();
    sel(3'd3); cash(2'd2);
    for (int i = 0; i < 19; i++) tick();
    n_checks++; if (state !== 2'd1 || refund_vld !== 1'b0) begin n_fail++; $display("FAIL to_19: got state %0d refund %b want 1 0", state, refund_vld); end
    tick();
    n_checks++; if (state !== 2'd0 || refund_vld !== 1'b1 || refund_amt !== 6'd5 || credit !== 6'd0) begin n_fail++; $display("FAIL to_20: got state %0d vld %b amt %0d credit %0d want 0 1 5 0", state, refund_vld, refund_amt, credit); end
    sel(3'd5);
    n_checks++; if (err !== 1'b1 || state !== 2'd0) begin n_fail++; $display("FAIL to_badid: got err %b state %0d want 1 0", err, state); end
  endtask

  task automatic test_saturation();
    do_reset();
    sel(3'd0);
    for (int i = 0; i < 6; i++) cash(2'd3);
    n_checks++; if (credit !== 6'd60 || err !== 1'b0) begin n_fail++; $display("FAIL sat_60: got %0d err %b want 60 0", credit, err); end
    cash(2'd3);
    n_checks++; if (err !== 1'b1 || credit !== 6'd60) begin n_fail++; $display("FAIL sat_70: got err %b credit %0d want 1 60", err, credit); end
    cash(2'd2);
    n_checks++; if (err !== 1'b1 || credit !== 6'd60) begin n_fail++; $display("FAIL sat_65: got err %b credit %0d want 1 60", err, credit); end
    cash(2'd1);
    n_checks++; if (err !== 1'b0 || credit !== 6'd62) begin n_fail++; $display("FAIL sat_62: got err %b credit %0d want 0 62", err, credit); end
  endtask

  task automatic test_concurrent_reset();
    do_reset();
    sel(3'd0); cash(2'd3); pick(2'd2); step();
    n_checks++; if (refund_vld !== 1'b0 || busy !== 4'b0001) begin n_fail++; $display("FAIL cc_m0: got refund %b busy %b want 0 0001", refund_vld, busy); end
    sel(3'd1); cash(2'd2); cash(2'd1); pick(2'd1); step();
    n_checks++; if (busy !== 4'b0011) begin n_fail++; $display("FAIL cc_m1: got busy %b want 0011", busy); end
    for (int i = 0; i < 3; i++) tick();
    view_id = 3'd0; #1;
    n_checks++; if (rem_view !== 8'd9) begin n_fail++; $display("FAIL cc_view0: got %0d want 9", rem_view); end
    view_id = 3'd1; #1;
    n_checks++; if (rem_view !== 8'd5) begin n_fail++; $display("FAIL cc_view1: got %0d want 5", rem_view); end
    view_id = 3'd5; #1;
    n_checks++; if (rem_view !== 8'd0) begin n_fail++; $display("FAIL cc_view5: got %0d want 0", rem_view); end
    view_id = 3'd1;
    sel(3'd2); cash(2'd3);
    n_checks++; if (state !== 2'd1 || credit !== 6'd10) begin n_fail++; $display("FAIL cc_pay: got state %0d credit %0d want 1 10", state, credit); end
    reset = 1'b0; #1;
    n_checks++; if (state !== 2'd0 || credit !== 6'd0 || busy !== 4'd0 || rem_view !== 8'd0) begin n_fail++; $display("FAIL cc_rst: got state %0d credit %0d busy %b rem %0d want 0 0 0000 0", state, credit, busy, rem_view); end
    step();
    n_checks++; if (refund_vld !== 1'b0 || done !== 4'd0) begin n_fail++; $display("FAIL cc_rst_refund: got refund %b done %b want 0 0000", refund_vld, done); end
    reset = 1'b1; step();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_mode_price();
    test_refund_busy();
    test_cancel_priority();
    test_timeout();
    test_saturation();
    test_concurrent_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
